// File: rtl/wb_pkg.sv
// Shared widths, register-file write encodings and the write-queue entry type
// for the writeback controller.
package wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;

  localparam logic [1:0] RW_IDLE  = 2'b00;
  localparam logic [1:0] RW_WRITE = 2'b01;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] dest;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Register-based write queue with a two-entry push port and single pop.
// Entries are exposed oldest-first (age_entry[0] is the head) for hazard lookup.
module wb_fifo
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push0_en,
  input  wb_entry_t              push0_entry,
  input  logic                   push1_en,
  input  wb_entry_t              push1_entry,
  input  logic                   pop,
  output logic [$clog2(DEPTH):0] count,
  output logic [DEPTH-1:0]       age_valid,
  output wb_entry_t              age_entry [DEPTH]
);

  localparam int PTR_W = $clog2(DEPTH);

  typedef logic [PTR_W-1:0] ptr_t;
  typedef logic [PTR_W:0]   cnt_t;

  wb_entry_t mem [DEPTH];
  ptr_t      wr_ptr_reg, wr_ptr_next;
  ptr_t      rd_ptr_reg, rd_ptr_next;
  cnt_t      count_reg, count_next;

  // push1 is only ever used together with push0, so slots stay contiguous.
  always_comb begin
    wr_ptr_next = wr_ptr_reg + ptr_t'(push0_en) + ptr_t'(push1_en);
    rd_ptr_next = rd_ptr_reg + ptr_t'(pop);
    count_next  = count_reg + cnt_t'(push0_en) + cnt_t'(push1_en) - cnt_t'(pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      wr_ptr_reg <= wr_ptr_next;
      rd_ptr_reg <= rd_ptr_next;
      count_reg  <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      if (push0_en) mem[wr_ptr_reg] <= push0_entry;
      if (push1_en) mem[wr_ptr_reg + ptr_t'(1)] <= push1_entry;
    end
  end

  generate
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_age
      assign age_entry[gi] = mem[rd_ptr_reg + ptr_t'(gi)];
      assign age_valid[gi] = cnt_t'(gi) < count_reg;
    end
  endgenerate

  assign count = count_reg;

endmodule

// File: rtl/writeback_ctrl.sv
// Writeback arbitration between load and ALU results, register-file write port,
// and read-port hazard detection. Define WB_BYPASS_EN to turn hazards into bypass hits.
module writeback_ctrl
  import wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alu_valid,
  output logic                  alu_ready,
  input  logic [REG_ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0]     alu_data,
  input  logic                  ld_valid,
  output logic                  ld_ready,
  input  logic [REG_ADDR_W-1:0] ld_dest,
  input  logic [DATA_W-1:0]     ld_data,
  output logic [REG_ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0]     WriteData,
  output logic [1:0]            RegWrite,
  input  logic [REG_ADDR_W-1:0] Read1,
  input  logic [REG_ADDR_W-1:0] Read2,
  output logic                  hazard1,
  output logic                  hazard2,
  output logic                  byp_hit1,
  output logic                  byp_hit2,
  output logic [DATA_W-1:0]     byp_data1,
  output logic [DATA_W-1:0]     byp_data2
);

  localparam int CNT_W = $clog2(DEPTH) + 1;
  typedef logic [CNT_W-1:0] cnt_t;

  cnt_t      count;
  cnt_t      free_slots;
  logic [DEPTH-1:0] age_valid;
  wb_entry_t age_entry [DEPTH];
  wb_entry_t ld_entry, alu_entry;
  logic      ld_push, alu_push, pop;
  logic [REG_ADDR_W-1:0] rd_addr [2];

  // Readiness uses start-of-cycle occupancy; the concurrent pop is not credited.
  assign free_slots = cnt_t'(DEPTH) - count;
  assign ld_ready   = !rst && (count < cnt_t'(DEPTH));
  assign alu_ready  = !rst && ((free_slots >= cnt_t'(2)) || ((free_slots != '0) && !ld_valid));

  // Writes to r0 complete the handshake but are dropped here.
  assign ld_push  = ld_valid && ld_ready && (ld_dest != '0);
  assign alu_push = alu_valid && alu_ready && (alu_dest != '0);

  assign ld_entry  = {ld_dest, ld_data};
  assign alu_entry = {alu_dest, alu_data};
  assign pop       = !rst && age_valid[0];

  wb_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .push0_en   (ld_push || alu_push),
    .push0_entry(ld_push ? ld_entry : alu_entry),
    .push1_en   (ld_push && alu_push),
    .push1_entry(alu_entry),
    .pop        (pop),
    .count      (count),
    .age_valid  (age_valid),
    .age_entry  (age_entry)
  );

  always_comb begin
    RegWrite  = RW_IDLE;
    WriteReg  = '0;
    WriteData = '0;
    if (pop) begin
      RegWrite  = RW_WRITE;
      WriteReg  = age_entry[0].dest;
      WriteData = age_entry[0].data;
    end
  end

  assign rd_addr[0] = Read1;
  assign rd_addr[1] = Read2;

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_port
      logic              hit;
      logic [DATA_W-1:0] hit_data;

      // Scan oldest to youngest so the last match holds the youngest value.
      always_comb begin
        hit      = 1'b0;
        hit_data = '0;
        for (int k = 0; k < DEPTH; k++) begin
          if (!rst && (rd_addr[gi] != '0) && age_valid[k] &&
              (age_entry[k].dest == rd_addr[gi])) begin
            hit      = 1'b1;
            hit_data = age_entry[k].data;
          end
        end
      end
    end
  endgenerate

`ifdef WB_BYPASS_EN
  assign byp_hit1  = g_port[0].hit;
  assign byp_hit2  = g_port[1].hit;
  assign byp_data1 = g_port[0].hit_data;
  assign byp_data2 = g_port[1].hit_data;
  // Every pending match is served by the bypass, so no stall is ever raised.
  assign hazard1   = 1'b0;
  assign hazard2   = 1'b0;
`else
  logic unused_hit_data;
  assign unused_hit_data = ^{g_port[0].hit_data, g_port[1].hit_data};
  assign hazard1   = g_port[0].hit;
  assign hazard2   = g_port[1].hit;
  assign byp_hit1  = 1'b0;
  assign byp_hit2  = 1'b0;
  assign byp_data1 = '0;
  assign byp_data2 = '0;
`endif

endmodule

// File: tb/tb_writeback_ctrl.sv
// Scoreboard bench for writeback_ctrl: stimulus pushes expected writes, a
// negedge monitor pops and compares every register-file write and hazard output.
module tb_writeback_ctrl;
  import wb_pkg::*;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        alu_valid = 1'b0, ld_valid = 1'b0;
  logic        alu_ready, ld_ready;
  logic [4:0]  alu_dest = '0, ld_dest = '0, Read1 = '0, Read2 = '0;
  logic [31:0] alu_data = '0, ld_data = '0;
  logic [4:0]  WriteReg;
  logic [31:0] WriteData;
  logic [1:0]  RegWrite;
  logic        hazard1, hazard2, byp_hit1, byp_hit2;
  logic [31:0] byp_data1, byp_data2;

  int checks = 0;
  int errors = 0;
  int occ_m  = 0;
  wb_entry_t exp_q [$];

  always #5 clk = ~clk;

  writeback_ctrl #(.DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_ready(alu_ready), .alu_dest(alu_dest), .alu_data(alu_data),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_dest(ld_dest), .ld_data(ld_data),
    .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .Read1(Read1), .Read2(Read2), .hazard1(hazard1), .hazard2(hazard2),
    .byp_hit1(byp_hit1), .byp_hit2(byp_hit2), .byp_data1(byp_data1), .byp_data2(byp_data2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // Monitor: the queue model holds exactly what the DUT should hold this cycle.
  always @(negedge clk) begin
    logic        hz1, hz2;
    logic [31:0] bd1, bd2;
    wb_entry_t   e;
    if (rst) begin
      occ_m = 0;
      chk("rst_regwrite", RegWrite, RW_IDLE);
      chk("rst_writereg", WriteReg, 0);
      chk("rst_writedata", WriteData, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_alu_ready", alu_ready, 0);
      chk("rst_hazards", {hazard1, hazard2, byp_hit1, byp_hit2}, 0);
    end else begin
      hz1 = 1'b0; hz2 = 1'b0; bd1 = '0; bd2 = '0;
      foreach (exp_q[i]) begin
        if (Read1 != 0 && exp_q[i].dest == Read1) begin hz1 = 1'b1; bd1 = exp_q[i].data; end
        if (Read2 != 0 && exp_q[i].dest == Read2) begin hz2 = 1'b1; bd2 = exp_q[i].data; end
      end
`ifdef WB_BYPASS_EN
      chk("byp_hit1", byp_hit1, hz1);
      chk("byp_hit2", byp_hit2, hz2);
      chk("byp_data1", byp_data1, bd1);
      chk("byp_data2", byp_data2, bd2);
      chk("hazards_masked", {hazard1, hazard2}, 0);
`else
      chk("hazard1", hazard1, hz1);
      chk("hazard2", hazard2, hz2);
      chk("byp_tied", {byp_hit1, byp_hit2, byp_data1, byp_data2}, 0);
`endif
      occ_m = exp_q.size();
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("regwrite", RegWrite, RW_WRITE);
        chk("writereg", WriteReg, e.dest);
        chk("writedata", WriteData, e.data);
        $display("write reg=%0d data=%08h (expected reg=%0d data=%08h)", WriteReg, WriteData, e.dest, e.data);
      end else begin
        chk("idle_regwrite", RegWrite, RW_IDLE);
        chk("idle_writereg", WriteReg, 0);
        chk("idle_writedata", WriteData, 0);
      end
    end
  end

  task automatic cycle(input logic lv, input logic [4:0] ld_d, input logic [31:0] ld_x,
                       input logic av, input logic [4:0] al_d, input logic [31:0] al_x,
                       input logic [4:0] r1, input logic [4:0] r2);
    logic exp_ld, exp_alu;
    @(posedge clk); #1;
    ld_valid = lv; ld_dest = ld_d; ld_data = ld_x;
    alu_valid = av; alu_dest = al_d; alu_data = al_x;
    Read1 = r1; Read2 = r2;
    @(negedge clk); #1;
    if (!rst) begin
      exp_ld  = occ_m < DEPTH;
      exp_alu = (DEPTH - occ_m >= 2) || ((DEPTH - occ_m >= 1) && !lv);
      chk("ld_ready", ld_ready, exp_ld);
      chk("alu_ready", alu_ready, exp_alu);
      if (lv && exp_ld && ld_d != 0) begin
        exp_q.push_back({ld_d, ld_x});
        $display("push ld reg=%0d data=%08h", ld_d, ld_x);
      end
      if (av && exp_alu && al_d != 0) begin
        exp_q.push_back({al_d, al_x});
        $display("push alu reg=%0d data=%08h", al_d, al_x);
      end
    end
  endtask

  task automatic idle(input logic [4:0] r1, input logic [4:0] r2);
    cycle(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, r1, r2);
  endtask

  task automatic do_rst();
    @(posedge clk); #1;
    rst = 1'b1; ld_valid = 1'b0; alu_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    @(posedge clk); #1;
    rst = 1'b0;
    idle(0, 0);

    // ALU-only write of reg 3
    cycle(0, 0, 0, 1, 5'd3, 32'h1234, 0, 0);
    idle(5'd3, 0);
    chk("alu_only_writereg", WriteReg, 3);
    idle(5'd3, 0);
    chk("alu_only_idle", RegWrite, RW_IDLE);

    // Load ahead of ALU to the same register
    cycle(1, 5'd5, 32'hAAAA, 1, 5'd5, 32'hBBBB, 5'd5, 0);
    idle(5'd5, 0);
    chk("dual_first_data", WriteData, 32'hAAAA);
    chk("dual_pending_a", hazard1 | byp_hit1, 1);
    idle(5'd5, 0);
    chk("dual_second_data", WriteData, 32'hBBBB);
    chk("dual_pending_b", hazard1 | byp_hit1, 1);
    idle(5'd5, 0);
    chk("dual_cleared", hazard1 | byp_hit1, 0);

    // Destination zero is accepted but dropped
    cycle(0, 0, 0, 1, 5'd0, 32'hFFFF, 0, 0);
    idle(0, 0);
    chk("dest0_no_write", RegWrite, RW_IDLE);
    chk("dest0_no_hazard", hazard1, 0);

    // Fill with dual pushes until ALU is refused at one free slot
    cycle(1, 5'd1, 32'h101, 1, 5'd2, 32'h102, 0, 0);
    cycle(1, 5'd3, 32'h103, 1, 5'd4, 32'h104, 0, 0);
    cycle(1, 5'd5, 32'h105, 1, 5'd6, 32'h106, 0, 0);
    chk("alu_ready_one_free", alu_ready, 0);
    chk("ld_ready_one_free", ld_ready, 1);

    for (int i = 0; i < 100; i++) begin
      cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
            5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    end
    repeat (6) idle(0, 0);

    // Reset with three entries queued
    cycle(1, 5'd9, 32'h900, 1, 5'd10, 32'hA00, 0, 0);
    cycle(1, 5'd11, 32'hB00, 1, 5'd12, 32'hC00, 0, 0);
    do_rst();
    idle(5'd11, 5'd12);
    chk("post_rst_regwrite", RegWrite, RW_IDLE);
    chk("post_rst_ld_ready", ld_ready, 1);
    chk("post_rst_alu_ready", alu_ready, 1);
    chk("post_rst_no_hazard", {hazard1, hazard2}, 0);

    // Two pending writes to reg 7: youngest value must be visible
    cycle(1, 5'd7, 32'h11, 1, 5'd7, 32'h22, 0, 0);
    idle(0, 5'd7);
`ifdef WB_BYPASS_EN
    chk("bypass_hit2", byp_hit2, 1);
    chk("bypass_data2", byp_data2, 32'h22);
    chk("bypass_hazard2", hazard2, 0);
`else
    chk("nobypass_hazard2", hazard2, 1);
    chk("nobypass_hit2", byp_hit2, 0);
`endif
    repeat (4) idle(0, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
